// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset PC, the NOP encoding and the
// {pc, instr} entry carried between fetch and decode.
package mips_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Prefetch queue entry array: one synchronous write port and one combinational read port.
// The array has no reset because the empty queue masks its contents on the head outputs.
module fq_storage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between IF and ID: owns the fetch PC, buffers
// fetched {pc, instr} pairs, and supports flush/redirect, halt and statistics.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  PC_RESET = PC_RESET_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        imem_addr_o,
  input  logic [DATA_W-1:0]        imem_data_i,
  input  logic                     halt_i,
  input  logic                     flush_i,
  input  logic [ADDR_W-1:0]        flush_pc_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [DATA_W-1:0]        id_instr_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [ADDR_W-1:0]        id_pcplus4_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              fetched_cnt_o,
  output logic [31:0]              discarded_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       fetched_cnt, discarded_cnt;
  logic              push, pop;
  logic [EW-1:0]     rd_entry;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_instr;

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .PW    (PW)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({pc, imem_data_i}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign head_pc    = rd_entry[EW-1:DATA_W];
  assign head_instr = rd_entry[DATA_W-1:0];

  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o && id_ready_i;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push       = !flush_i && !halt_i && ((count < CW'(DEPTH)) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= PC_RESET;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fetched_cnt   <= '0;
      discarded_cnt <= '0;
    end else if (flush_i) begin
      // A head offered this cycle is counted as discarded, not as accepted.
      count         <= '0;
      rd_ptr        <= wr_ptr;
      pc            <= {flush_pc_i[ADDR_W-1:2], 2'b00};
      discarded_cnt <= discarded_cnt + 32'(count);
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        pc          <= pc + ADDR_W'(4);
        fetched_cnt <= fetched_cnt + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign imem_addr_o     = pc;
  assign count_o         = count;
  assign fetched_cnt_o   = fetched_cnt;
  assign discarded_cnt_o = discarded_cnt;

  assign id_instr_o   = id_valid_o ? head_instr : DATA_W'(INSTR_NOP);
  assign id_pc_o      = id_valid_o ? head_pc : '0;
  assign id_pcplus4_o = id_valid_o ? head_pc + ADDR_W'(4) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model checked
// every cycle, plus hand-computed literal checks for each scenario.
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_data;
  logic        halt = 1'b0, flush = 1'b0, id_ready = 1'b1;
  logic [31:0] flush_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pcplus4;
  logic [2:0]  count;
  logic [31:0] fetched_cnt, discarded_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 32'hFFFF_FFFF;

  fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .PC_RESET(32'h0040_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr_o     (imem_addr),
    .imem_data_i     (imem_data),
    .halt_i          (halt),
    .flush_i         (flush),
    .flush_pc_i      (flush_pc),
    .id_valid_o      (id_valid),
    .id_ready_i      (id_ready),
    .id_instr_o      (id_instr),
    .id_pc_o         (id_pc),
    .id_pcplus4_o    (id_pcplus4),
    .count_o         (count),
    .fetched_cnt_o   (fetched_cnt),
    .discarded_cnt_o (discarded_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} entries
  fq_entry_t   m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched, m_disc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc      = 32'h0040_0000;
      m_fetched = 0;
      m_disc    = 0;
    end else begin
      bit do_pop;
      fq_entry_t e;
      do_pop = (m_q.size() != 0) && id_ready;
      if (flush) begin
        m_disc = m_disc + 32'(m_q.size());
        m_q.delete();
        m_pc = {flush_pc[31:2], 2'b00};
      end else begin
        bit room;
        room = (m_q.size() < DEPTH) || do_pop;
        if (do_pop) void'(m_q.pop_front());
        if (!halt && room) begin
          e.pc    = m_pc;
          e.instr = m_pc ^ 32'hFFFF_FFFF;
          m_q.push_back(e);
          m_pc      = m_pc + 32'd4;
          m_fetched = m_fetched + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("imem_addr", imem_addr, m_pc);
      check("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
      check("count", {29'b0, count}, 32'(m_q.size()));
      check("id_pc", id_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
      check("id_instr", id_instr, (m_q.size() != 0) ? m_q[0].instr : INSTR_NOP);
      check("id_pcplus4", id_pcplus4, (m_q.size() != 0) ? m_q[0].pc + 32'd4 : 32'h0);
      check("fetched_cnt", fetched_cnt, m_fetched);
      check("discarded_cnt", discarded_cnt, m_disc);
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Reset asserted and released between clock edges
  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    flush = 1'b0;
    halt  = 1'b0;
    id_ready = ready;
    #1;
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_count", {29'b0, count}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0040_0000);
    check("rst_fetched", fetched_cnt, 32'h0);
    check("rst_discarded", discarded_cnt, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state before release, then steady-state streaming
    #11;
    check("reset_imem_addr", imem_addr, 32'h0040_0000);
    check("reset_valid", {31'b0, id_valid}, 32'h0);
    check("reset_instr", id_instr, 32'h0);
    rst_n = 1'b1;
    at_neg();
    check("stream_pc0", id_pc, 32'h0040_0000);
    check("stream_instr0", id_instr, 32'hFFBF_FFFF);
    at_neg();
    check("stream_pc1", id_pc, 32'h0040_0004);
    check("stream_count1", {29'b0, count}, 32'd1);
    at_neg();
    check("stream_pc2", id_pc, 32'h0040_0008);
    check("stream_pcplus4", id_pcplus4, 32'h0040_000C);
    check("stream_fetched3", fetched_cnt, 32'd3);

    // Back-pressure: fill to DEPTH, then drain in order
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) at_neg();
    check("full_count", {29'b0, count}, 32'd4);
    check("full_imem_addr", imem_addr, 32'h0040_0010);
    check("full_fetched", fetched_cnt, 32'd4);
    check("full_head", id_pc, 32'h0040_0000);
    id_ready = 1'b1;
    at_neg();
    check("fullpop_count", {29'b0, count}, 32'd4);
    check("fullpop_fetched", fetched_cnt, 32'd5);
    check("fullpop_imem_addr", imem_addr, 32'h0040_0014);
    for (int i = 1; i <= 4; i++) begin
      check("drain_pc", id_pc, 32'h0040_0000 + 32'(4 * i));
      at_neg();
    end

    // Flush with count 3 and a coincident pop
    do_reset(1'b0);
    at_neg();
    at_neg();
    at_neg();
    check("preflush_count", {29'b0, count}, 32'd3);
    id_ready = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h0040_0103;
    at_neg();
    flush = 1'b0;
    check("flush_count", {29'b0, count}, 32'd0);
    check("flush_valid", {31'b0, id_valid}, 32'd0);
    check("flush_discarded", discarded_cnt, 32'd3);
    check("flush_imem_addr", imem_addr, 32'h0040_0100);
    at_neg();
    check("flush_target_pc", id_pc, 32'h0040_0100);
    check("flush_target_instr", id_instr, 32'hFFBF_FEFF);

    // Halt with 2 entries drains while fetch is frozen
    do_reset(1'b0);
    at_neg();
    at_neg();
    check("prehalt_count", {29'b0, count}, 32'd2);
    halt = 1'b1;
    id_ready = 1'b1;
    at_neg();
    check("halt_count1", {29'b0, count}, 32'd1);
    at_neg();
    check("halt_count0", {29'b0, count}, 32'd0);
    check("halt_instr_nop", id_instr, 32'h0);
    check("halt_imem_addr", imem_addr, 32'h0040_0008);
    check("halt_fetched", fetched_cnt, 32'd2);
    flush    = 1'b1;
    flush_pc = 32'h0050_0002;
    at_neg();
    flush = 1'b0;
    check("haltflush_imem_addr", imem_addr, 32'h0050_0000);
    check("haltflush_count", {29'b0, count}, 32'd0);
    at_neg();
    check("haltflush_nopush", fetched_cnt, 32'd2);
    halt = 1'b0;
    at_neg();
    at_neg();

    // Asynchronous reset mid-cycle with 3 entries
    do_reset(1'b0);
    at_neg();
    at_neg();
    at_neg();
    check("prereset_count", {29'b0, count}, 32'd3);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) at_neg();
    check("post_reset_pc", id_pc, 32'h0040_000C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
